// File: rtl/uart_result_framer.sv
// Round-robin result-word serializer: captures one channel's word at a time and
// streams it LSB-first to a UART, optionally framed with sync/ID/XOR-checksum bytes.
module uart_result_framer #(
  parameter int          RESULT_BYTES = 12,
  parameter int          NUM_CH       = 2,
  parameter int          FRAMING      = 1,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CH*RESULT_BYTES*8-1:0]    ch_results,
  input  logic [NUM_CH-1:0]                   ch_valid,
  output logic [NUM_CH-1:0]                   ch_ready,
  input  logic                                rdy_out,
  output logic                                output_valid,
  output logic [7:0]                          data_out,
  output logic                                busy,
  output logic [2:0]                          dbg_state
);
  localparam int WW  = RESULT_BYTES * 8;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BCW = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;

  // Handshakes: a channel word moves on an edge with ch_valid[k] && ch_ready[k];
  // a byte moves on an edge with output_valid && rdy_out.
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ID, S_PAYLOAD, S_CKSUM} state_t;

  state_t           state_q, state_d;
  logic [WW-1:0]    shreg_q, shreg_d;
  logic [CHW-1:0]   cur_ch_q, cur_ch_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]       cksum_q, cksum_d;
  logic [CHW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             output_valid_q, output_valid_d;
  logic [7:0]       data_out_q, data_out_d;

  logic [CHW-1:0]   grant;
  logic             grant_vld;
  logic [WW-1:0]    grant_word;
  logic [CHW:0]     scan_idx;
  logic [CHW:0]     rr_inc;
  logic [CHW-1:0]   next_rr;
  logic             accept;
  logic             last_payload;

  function automatic logic [7:0] zext8(input logic [CHW-1:0] v);
    logic [7:0] r;
    r = '0;
    r[CHW-1:0] = v;
    return r;
  endfunction

  // First valid channel scanning upward from rr_ptr, wrapping at NUM_CH.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + (CHW+1)'(i);
      if (scan_idx >= (CHW+1)'(NUM_CH)) scan_idx = scan_idx - (CHW+1)'(NUM_CH);
      for (int k = 0; k < NUM_CH; k++) begin
        if (!grant_vld && ch_valid[k] && (scan_idx[CHW-1:0] == CHW'(k))) begin
          grant     = CHW'(k);
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_word = '0;
    ch_ready   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant == CHW'(k)) grant_word = ch_results[k*WW +: WW];
      ch_ready[k] = (state_q == S_IDLE) && !rst && grant_vld && (grant == CHW'(k));
    end
  end

  always_comb begin
    rr_inc  = {1'b0, cur_ch_q} + (CHW+1)'(1);
    next_rr = (rr_inc == (CHW+1)'(NUM_CH)) ? '0 : rr_inc[CHW-1:0];
  end

  assign accept       = output_valid_q && rdy_out;
  assign last_payload = (byte_cnt_q == BCW'(RESULT_BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      shreg_q        <= '0;
      cur_ch_q       <= '0;
      byte_cnt_q     <= '0;
      cksum_q        <= '0;
      rr_ptr_q       <= '0;
      output_valid_q <= 1'b0;
      data_out_q     <= 8'h00;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      cur_ch_q       <= cur_ch_d;
      byte_cnt_q     <= byte_cnt_d;
      cksum_q        <= cksum_d;
      rr_ptr_q       <= rr_ptr_d;
      output_valid_q <= output_valid_d;
      data_out_q     <= data_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cur_ch_d   = cur_ch_q;
    byte_cnt_d = byte_cnt_q;
    cksum_d    = cksum_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          shreg_d    = grant_word;
          cur_ch_d   = grant;
          byte_cnt_d = '0;
          cksum_d    = zext8(grant);
          state_d    = (FRAMING != 0) ? S_SYNC : S_PAYLOAD;
        end
      end
      S_SYNC:    if (accept) state_d = S_ID;
      S_ID:      if (accept) state_d = S_PAYLOAD;
      S_PAYLOAD: begin
        if (accept) begin
          shreg_d    = shreg_q >> 8;
          cksum_d    = cksum_q ^ shreg_q[7:0];
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (last_payload) begin
            if (FRAMING != 0) begin
              state_d = S_CKSUM;
            end else begin
              state_d  = S_IDLE;
              rr_ptr_d = next_rr;
            end
          end
        end
      end
      S_CKSUM: begin
        if (accept) begin
          state_d  = S_IDLE;
          rr_ptr_d = next_rr;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view, so a held byte stays put
  // until accepted and the following byte appears on the cycle after the accept.
  always_comb begin
    output_valid_d = 1'b1;
    data_out_d     = 8'h00;
    case (state_d)
      S_SYNC:    data_out_d = SYNC_BYTE;
      S_ID:      data_out_d = zext8(cur_ch_d);
      S_PAYLOAD: data_out_d = shreg_d[7:0];
      S_CKSUM:   data_out_d = cksum_d;
      default:   output_valid_d = 1'b0;
    endcase
  end

  assign output_valid = output_valid_q;
  assign data_out     = data_out_q;
  assign busy         = (state_q != S_IDLE);
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_uart_result_framer.sv
// Directed bench for uart_result_framer: default-parameter instance plus a
// FRAMING=0 / RESULT_BYTES=3 / NUM_CH=1 instance.
module tb_uart_result_framer;
  logic         clk;
  logic         rst;
  logic [191:0] ch_results;
  logic [1:0]   ch_valid;
  logic [1:0]   ch_ready;
  logic         rdy_out;
  logic         output_valid;
  logic [7:0]   data_out;
  logic         busy;
  logic [2:0]   dbg_state;

  logic [23:0]  f_results;
  logic [0:0]   f_valid;
  logic [0:0]   f_ready;
  logic         f_rdy;
  logic         f_ov;
  logic [7:0]   f_dout;
  logic         f_busy;
  logic [2:0]   f_dbg;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int n_cyc, first_acc, last_acc, gap_cnt, stab_err, ready_cnt;

  localparam logic [95:0] W_A = 96'h0C0B0A09_0807060504030201;  // cksum: ch0->0C, ch1->0D
  localparam logic [95:0] W_B = 96'hF0E0D0C0_B0A09080_70605040;  // cksum: ch0->00, ch1->01
  localparam logic [95:0] W_C = 96'hFFFFFFFF_00000000_12345678;  // cksum: ch0->08

  uart_result_framer dut (
    .clk(clk), .rst(rst), .ch_results(ch_results), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .rdy_out(rdy_out), .output_valid(output_valid),
    .data_out(data_out), .busy(busy), .dbg_state(dbg_state)
  );

  uart_result_framer #(.RESULT_BYTES(3), .NUM_CH(1), .FRAMING(0)) dut_nf (
    .clk(clk), .rst(rst), .ch_results(f_results), .ch_valid(f_valid),
    .ch_ready(f_ready), .rdy_out(f_rdy), .output_valid(f_ov),
    .data_out(f_dout), .busy(f_busy), .dbg_state(f_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: expected-frame builder
  task automatic push_frame(input logic [7:0] ch, input logic [95:0] word, input logic [7:0] ck);
    exp_q.push_back(8'hA5);
    exp_q.push_back(ch);
    for (int i = 0; i < 12; i++) exp_q.push_back(word[i*8 +: 8]);
    exp_q.push_back(ck);
  endtask

  // driver/monitor: run until n bytes are accepted or the cycle budget expires
  task automatic collect(input int n, input int budget, input bit rnd, input bit drop);
    bit         prev_hold;
    logic [7:0] prev_dout;
    got_q.delete();
    n_cyc = 0; first_acc = -1; last_acc = -1;
    gap_cnt = 0; stab_err = 0; ready_cnt = 0;
    prev_hold = 1'b0; prev_dout = 8'h00;
    while (got_q.size() < n && n_cyc < budget) begin
      @(negedge clk);
      n_cyc++;
      if (drop) ch_valid = 2'b00;
      rdy_out = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (ch_ready != 2'b00) ready_cnt++;
      if (prev_hold && (!output_valid || data_out !== prev_dout)) stab_err++;
      if (first_acc >= 0 && !output_valid) gap_cnt++;
      if (output_valid && rdy_out) begin
        got_q.push_back(data_out);
        if (first_acc < 0) first_acc = n_cyc;
        last_acc = n_cyc;
      end
      prev_hold = output_valid && !rdy_out;
      prev_dout = data_out;
    end
  endtask

  task automatic go_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ch_valid = 2'b00;
      rdy_out  = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    ch_valid = 2'b11;
    #1;
    total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL rst_ov got=%b exp=0", output_valid); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h exp=00", data_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (ch_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", ch_ready); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    total++; if (f_ov !== 1'b0) begin bad++; $display("FAIL rst_nf_ov got=%b exp=0", f_ov); end
    @(negedge clk);
    ch_valid = 2'b00;
    rst = 1'b0;
    go_idle(2);
  endtask

  task automatic test_single_ch0;
    exp_q.delete();
    push_frame(8'h00, W_A, 8'h0C);
    @(negedge clk);
    ch_results = {96'h0, W_A};
    ch_valid = 2'b01;
    rdy_out = 1'b1;
    #1;
    total++; if (ch_ready !== 2'b01) begin bad++; $display("FAIL s0_ready got=%b exp=01", ch_ready); end
    collect(15, 40, 1'b0, 1'b1);
    total++; if (got_q.size() != 15) begin bad++; $display("FAIL s0_len got=%0d exp=15", got_q.size()); end
    for (int i = 0; i < 15 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL s0_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (first_acc != 1) begin bad++; $display("FAIL s0_latency got=%0d exp=1", first_acc); end
    total++; if (last_acc - first_acc != 14) begin bad++; $display("FAIL s0_span got=%0d exp=14", last_acc - first_acc); end
    total++; if (ready_cnt != 0) begin bad++; $display("FAIL s0_ready_extra got=%0d exp=0", ready_cnt); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL s0_busy got=%b exp=1", busy); end
    go_idle(2);
    total++; if (busy !== 1'b0 || output_valid !== 1'b0) begin bad++; $display("FAIL s0_end got=%b%b exp=00", busy, output_valid); end
  endtask

  task automatic test_single_ch1;
    exp_q.delete();
    push_frame(8'h01, W_A, 8'h0D);
    @(negedge clk);
    ch_results = {W_A, 96'h0};
    ch_valid = 2'b10;
    #1;
    total++; if (ch_ready !== 2'b10) begin bad++; $display("FAIL s1_ready got=%b exp=10", ch_ready); end
    collect(15, 40, 1'b0, 1'b1);
    total++; if (got_q.size() != 15) begin bad++; $display("FAIL s1_len got=%0d exp=15", got_q.size()); end
    for (int i = 0; i < 15 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL s1_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    go_idle(2);
  endtask

  task automatic test_back_to_back;
    exp_q.delete();
    push_frame(8'h00, W_A, 8'h0C);
    push_frame(8'h01, W_B, 8'h01);
    push_frame(8'h00, W_A, 8'h0C);
    @(negedge clk);
    ch_results = {W_B, W_A};
    ch_valid = 2'b11;
    #1;
    total++; if (ch_ready !== 2'b01) begin bad++; $display("FAIL b2b_ready got=%b exp=01", ch_ready); end
    collect(45, 120, 1'b0, 1'b0);
    total++; if (got_q.size() != 45) begin bad++; $display("FAIL b2b_len got=%0d exp=45", got_q.size()); end
    for (int i = 0; i < 45 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (gap_cnt != 2) begin bad++; $display("FAIL b2b_gaps got=%0d exp=2", gap_cnt); end
    total++; if (last_acc - first_acc != 46) begin bad++; $display("FAIL b2b_span got=%0d exp=46", last_acc - first_acc); end
    total++; if (ready_cnt != 2) begin bad++; $display("FAIL b2b_ready_cycles got=%0d exp=2", ready_cnt); end
    go_idle(2);
  endtask

  task automatic test_backpressure;
    exp_q.delete();
    push_frame(8'h00, W_C, 8'h08);
    @(negedge clk);
    ch_results = {96'h0, W_C};
    ch_valid = 2'b01;
    collect(15, 400, 1'b1, 1'b1);
    total++; if (got_q.size() != 15) begin bad++; $display("FAIL bp_len got=%0d exp=15", got_q.size()); end
    for (int i = 0; i < 15 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (stab_err != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stab_err); end
    go_idle(2);
  endtask

  task automatic test_reset_mid_frame;
    exp_q.delete();
    push_frame(8'h01, W_A, 8'h0D);
    @(negedge clk);
    ch_results = {W_A, W_B};
    ch_valid = 2'b01;
    collect(5, 20, 1'b0, 1'b1);
    total++; if (got_q.size() != 5) begin bad++; $display("FAIL rm_pre_len got=%0d exp=5", got_q.size()); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL rm_ov got=%b exp=0", output_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rm_dout got=%h exp=00", data_out); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL rm_post_ov got=%b exp=0", output_valid); end
    ch_valid = 2'b11;
    #1;
    total++; if (ch_ready !== 2'b01) begin bad++; $display("FAIL rm_rr_ptr got=%b exp=01", ch_ready); end
    ch_valid = 2'b10;
    #1;
    total++; if (ch_ready !== 2'b10) begin bad++; $display("FAIL rm_ready1 got=%b exp=10", ch_ready); end
    collect(15, 40, 1'b0, 1'b1);
    total++; if (got_q.size() != 15) begin bad++; $display("FAIL rm_len got=%0d exp=15", got_q.size()); end
    for (int i = 0; i < 15 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rm_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    go_idle(2);
  endtask

  task automatic test_no_framing;
    logic [7:0] nf_exp[$];
    logic [7:0] nf_got[$];
    nf_exp = '{8'h11, 8'h22, 8'h33};
    @(negedge clk);
    f_results = 24'h332211;
    f_valid = 1'b1;
    f_rdy = 1'b1;
    #1;
    total++; if (f_ready !== 1'b1) begin bad++; $display("FAIL nf_ready got=%b exp=1", f_ready); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      f_valid = 1'b0;
      #1;
      if (f_ov && f_rdy) nf_got.push_back(f_dout);
    end
    total++; if (nf_got.size() != 3) begin bad++; $display("FAIL nf_len got=%0d exp=3", nf_got.size()); end
    for (int i = 0; i < 3 && i < nf_got.size(); i++) begin
      total++;
      if (nf_got[i] !== nf_exp[i]) begin bad++; $display("FAIL nf_byte%0d got=%h exp=%h", i, nf_got[i], nf_exp[i]); end
    end
    total++; if (f_busy !== 1'b0) begin bad++; $display("FAIL nf_busy got=%b exp=0", f_busy); end
  endtask

  initial begin
    rst = 1'b1;
    ch_results = '0;
    ch_valid = 2'b00;
    rdy_out = 1'b0;
    f_results = '0;
    f_valid = 1'b0;
    f_rdy = 1'b0;
    test_reset();
    test_single_ch0();
    test_single_ch1();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_no_framing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
